// File: rtl/picomem_timer_pkg.sv
// picomem_timer_pkg: register map, control bit positions and bus FSM states
package picomem_timer_pkg;
  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_PRESCALE = 3'd1;
  localparam logic [2:0] REG_COUNT    = 3'd2;
  localparam logic [2:0] REG_COMPARE  = 3'd3;
  localparam logic [2:0] REG_STATUS   = 3'd4;
  localparam int CTRL_EN          = 0;
  localparam int CTRL_AUTO_RELOAD = 1;
  localparam int CTRL_IRQ_EN      = 2;
  localparam int STATUS_MATCH     = 0;
  typedef enum logic {ST_IDLE, ST_ACK} state_t;
  function automatic logic [31:0] strb_mask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction
endpackage

// File: rtl/picomem_timer_prescaler.sv
// picomem_timer_prescaler: divides the clock into one-cycle ticks every prescale+1 cycles
module picomem_timer_prescaler
  import picomem_timer_pkg::*;
#(
  parameter int PRE_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [PRE_W-1:0] prescale,
  input  logic             clr,
  output logic             tick
);
  logic [PRE_W-1:0] r_cnt;
  assign tick = en && (r_cnt == prescale);
  // count enabled cycles; restart on terminal count, disable or prescale rewrite
  always_ff @(posedge clk) begin
    if (reset || !en || clr || tick) r_cnt <= '0;
    else r_cnt <= r_cnt + PRE_W'(1);
  end
endmodule

// File: rtl/picomem_timer.sv
// picomem_timer: PicoMem compare/match timer with prescaler, sticky match and level irq
module picomem_timer
  import picomem_timer_pkg::*;
#(
  parameter int PRE_W    = 16,
  parameter int ADDR_LSB = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_s_valid,
  output logic        mem_s_ready,
  input  logic [31:0] mem_s_addr,
  input  logic [31:0] mem_s_wdata,
  input  logic [3:0]  mem_s_wstrb,
  output logic [31:0] mem_s_rdata,
  output logic        irq
);
  state_t           r_state, w_next;
  logic [2:0]       r_ctrl;
  logic [PRE_W-1:0] r_prescale;
  logic [31:0]      r_count, r_compare, r_rdata;
  logic             r_match, r_irq;
  logic [2:0]       w_idx;
  logic [31:0]      w_mask, w_rd_val;
  logic             w_acc, w_wr, w_rd, w_tick, w_hit;
  logic             w_wr_ctrl, w_wr_pre, w_wr_count, w_wr_cmp, w_wr_status;
  logic             w_unused;
  assign w_unused    = ^{mem_s_addr[31:ADDR_LSB+3], mem_s_addr[ADDR_LSB-1:0]};
  assign w_idx       = mem_s_addr[ADDR_LSB+2:ADDR_LSB];
  assign w_mask      = strb_mask(mem_s_wstrb);
  assign w_acc       = (r_state == ST_IDLE) && mem_s_valid;
  assign w_wr        = w_acc && (|mem_s_wstrb);
  assign w_rd        = w_acc && !(|mem_s_wstrb);
  assign w_wr_ctrl   = w_wr && (w_idx == REG_CTRL);
  assign w_wr_pre    = w_wr && (w_idx == REG_PRESCALE);
  assign w_wr_count  = w_wr && (w_idx == REG_COUNT);
  assign w_wr_cmp    = w_wr && (w_idx == REG_COMPARE);
  assign w_wr_status = w_wr && (w_idx == REG_STATUS);
  assign w_hit       = w_tick && (r_count == r_compare);
  assign w_rd_val    = (w_idx == REG_CTRL)     ? {29'b0, r_ctrl}       :
                       (w_idx == REG_PRESCALE) ? 32'(r_prescale)       :
                       (w_idx == REG_COUNT)    ? r_count               :
                       (w_idx == REG_COMPARE)  ? r_compare             :
                       (w_idx == REG_STATUS)   ? {31'b0, r_match}      : 32'b0;
  assign mem_s_rdata = r_rdata;
  assign irq         = r_irq;
  picomem_timer_prescaler #(.PRE_W(PRE_W)) u_pre (
    .clk      (clk),
    .reset    (reset),
    .en       (r_ctrl[CTRL_EN]),
    .prescale (r_prescale),
    .clr      (w_wr_pre),
    .tick     (w_tick)
  );
  // access FSM state register
  always_ff @(posedge clk) begin
    r_state <= reset ? ST_IDLE : w_next;
  end
  // accept a request in IDLE, acknowledge for exactly one cycle in ACK
  always_comb begin
    w_next      = (r_state == ST_IDLE && mem_s_valid) ? ST_ACK : ST_IDLE;
    mem_s_ready = (r_state == ST_ACK);
  end
  // read data captured with the pre-update register values, zero outside ACK
  always_ff @(posedge clk) begin
    r_rdata <= (reset || !w_rd) ? 32'b0 : w_rd_val;
  end
  // configuration registers with per-byte strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl     <= '0;
      r_prescale <= '0;
      r_compare  <= '0;
    end else begin
      if (w_wr_ctrl) r_ctrl <= (r_ctrl & ~w_mask[2:0]) | (mem_s_wdata[2:0] & w_mask[2:0]);
      if (w_wr_pre) r_prescale <= (r_prescale & ~w_mask[PRE_W-1:0]) | (mem_s_wdata[PRE_W-1:0] & w_mask[PRE_W-1:0]);
      if (w_wr_cmp) r_compare <= (r_compare & ~w_mask) | (mem_s_wdata & w_mask);
    end
  end
  // counter, sticky match and irq; bus write beats tick, match set beats clear
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_match <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      if (w_wr_count) r_count <= (r_count & ~w_mask) | (mem_s_wdata & w_mask);
      else if (w_tick) r_count <= (w_hit && r_ctrl[CTRL_AUTO_RELOAD]) ? 32'b0 : r_count + 32'd1;
      if (w_hit) r_match <= 1'b1;
      else if (w_wr_status && w_mask[STATUS_MATCH] && mem_s_wdata[STATUS_MATCH]) r_match <= 1'b0;
      r_irq <= r_match && r_ctrl[CTRL_IRQ_EN];
    end
  end
endmodule

// File: tb/tb_picomem_timer.sv
// tb_picomem_timer: table vectors, corner sequences and random traffic against a reference model
module tb_picomem_timer;
  logic        clk = 0, reset = 0, mem_s_valid = 0;
  logic        mem_s_ready, irq;
  logic [31:0] mem_s_addr = 0, mem_s_wdata = 0, mem_s_rdata;
  logic [3:0]  mem_s_wstrb = 0;
  int n_chk = 0, n_err = 0;
  bit chk_on = 0;

  picomem_timer dut (
    .clk(clk), .reset(reset), .mem_s_valid(mem_s_valid), .mem_s_ready(mem_s_ready),
    .mem_s_addr(mem_s_addr), .mem_s_wdata(mem_s_wdata), .mem_s_wstrb(mem_s_wstrb),
    .mem_s_rdata(mem_s_rdata), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp;
  } vec_t;

  // reference model state
  logic [2:0]  m_ctrl;
  logic [15:0] m_pre;
  logic [31:0] m_cnt, m_cmp, m_rdata;
  logic        m_match, m_ready, m_irq;
  longint      m_el;

  function automatic logic [31:0] mrg(input logic [31:0] o, d, input logic [3:0] s);
    logic [31:0] r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] mval(input logic [2:0] ix);
    case (ix)
      3'd0: return {29'b0, m_ctrl};
      3'd1: return {16'b0, m_pre};
      3'd2: return m_cnt;
      3'd3: return m_cmp;
      3'd4: return {31'b0, m_match};
      default: return 32'b0;
    endcase
  endfunction

  always @(posedge clk) begin
    logic acc, wr, tk, hit;
    logic [2:0] ix;
    logic [31:0] t;
    if (reset) begin
      m_ctrl = 0; m_pre = 0; m_cnt = 0; m_cmp = 0; m_rdata = 0;
      m_match = 0; m_ready = 0; m_irq = 0; m_el = 0;
    end else begin
      ix = mem_s_addr[4:2];
      acc = mem_s_valid && !m_ready;
      wr = acc && (mem_s_wstrb != 0);
      tk = m_ctrl[0] && ((m_el % (longint'(m_pre) + 1)) == longint'(m_pre));
      hit = tk && (m_cnt == m_cmp);
      m_rdata = (acc && !wr) ? mval(ix) : 32'b0;
      m_irq = m_match && m_ctrl[2];
      m_el = (!m_ctrl[0] || (wr && ix == 3'd1)) ? 0 : m_el + 1;
      if (wr && ix == 3'd2) m_cnt = mrg(m_cnt, mem_s_wdata, mem_s_wstrb);
      else if (tk) m_cnt = (hit && m_ctrl[1]) ? 32'b0 : m_cnt + 1;
      if (hit) m_match = 1;
      else if (wr && ix == 3'd4 && mem_s_wstrb[0] && mem_s_wdata[0]) m_match = 0;
      t = mrg({29'b0, m_ctrl}, mem_s_wdata, mem_s_wstrb);
      if (wr && ix == 3'd0) m_ctrl = t[2:0];
      t = mrg({16'b0, m_pre}, mem_s_wdata, mem_s_wstrb);
      if (wr && ix == 3'd1) m_pre = t[15:0];
      if (wr && ix == 3'd3) m_cmp = mrg(m_cmp, mem_s_wdata, mem_s_wstrb);
      m_ready = acc;
    end
  end

  task automatic chk(input string n, input logic [31:0] a, e);
    n_chk++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  // cycle-by-cycle scoreboard of all outputs against the model
  always @(negedge clk) begin
    if (chk_on) begin
      chk("sb_ready", {31'b0, mem_s_ready}, {31'b0, m_ready});
      chk("sb_rdata", mem_s_rdata, m_rdata);
      chk("sb_irq", {31'b0, irq}, {31'b0, m_irq});
    end
  end

  task automatic do_reset();
    reset = 1; mem_s_valid = 0;
    @(posedge clk);
    chk_on = 1;
    @(posedge clk); #1;
    reset = 0;
  endtask

  task automatic bus(input logic [31:0] a, d, input logic [3:0] s, output logic [31:0] r);
    mem_s_addr = a; mem_s_wdata = d; mem_s_wstrb = s; mem_s_valid = 1;
    @(posedge clk); #1;
    chk("ack_ready", {31'b0, mem_s_ready}, 32'd1);
    r = mem_s_rdata;
    mem_s_valid = 0;
    @(posedge clk); #1;
    chk("idle_ready", {31'b0, mem_s_ready}, 32'd0);
  endtask

  task automatic wr(input logic [31:0] a, d);
    logic [31:0] r;
    bus(a, d, 4'hF, r);
  endtask

  task automatic rd_chk(input string n, input logic [31:0] a, e);
    logic [31:0] r;
    bus(a, 32'h0, 4'h0, r);
    chk(n, r, e);
  endtask

  vec_t vt[20];

  initial begin
    logic [31:0] r, d;
    logic [3:0] s;
    for (int i = 0; i < 8; i++) vt[i] = '{32'hC200_0000 + 32'(i*4), 32'h0, 4'h0, 32'h0};
    vt[8]  = '{32'hC200_000C, 32'hAABBCCDD, 4'b0010, 32'h0};
    vt[9]  = '{32'hC200_000C, 32'h0, 4'h0, 32'h0000CC00};
    vt[10] = '{32'hC200_0004, 32'hFFFFFFFF, 4'hF, 32'h0};
    vt[11] = '{32'hC200_0004, 32'h0, 4'h0, 32'h0000FFFF};
    vt[12] = '{32'hC200_0000, 32'hFFFFFFFA, 4'hF, 32'h0};
    vt[13] = '{32'hC200_0000, 32'h0, 4'h0, 32'h00000002};
    vt[14] = '{32'hC200_0018, 32'h12345678, 4'hF, 32'h0};
    vt[15] = '{32'hC200_0018, 32'h0, 4'h0, 32'h0};
    vt[16] = '{32'hC200_0008, 32'h11223344, 4'b1100, 32'h0};
    vt[17] = '{32'hC200_0008, 32'h0, 4'h0, 32'h11220000};
    vt[18] = '{32'hC200_0010, 32'hFFFFFFFF, 4'hF, 32'h0};
    vt[19] = '{32'hC200_0010, 32'h0, 4'h0, 32'h0};

    do_reset();
    chk("rst_ready", {31'b0, mem_s_ready}, 32'd0);
    chk("rst_rdata", mem_s_rdata, 32'd0);
    chk("rst_irq", {31'b0, irq}, 32'd0);
    for (int i = 0; i < 20; i++) begin
      bus(vt[i].addr, vt[i].wdata, vt[i].wstrb, r);
      if (vt[i].wstrb == 0) chk($sformatf("vec%0d", i), r, vt[i].exp);
    end

    // match timing with prescale 3, compare 5, auto reload
    do_reset();
    wr(32'hC200_0004, 3);
    wr(32'hC200_000C, 5);
    wr(32'hC200_0000, 7);
    repeat (23) @(posedge clk);
    #1 chk("match_irq_pre", {31'b0, irq}, 32'd0);
    @(posedge clk); #1 chk("match_irq_rise", {31'b0, irq}, 32'd1);
    rd_chk("reload_count", 32'hC200_0008, 32'h0);
    rd_chk("match_status", 32'hC200_0010, 32'h1);

    // wrap without match, sampled at three successive cycles
    for (int k = 0; k < 3; k++) begin
      do_reset();
      wr(32'hC200_0008, 32'hFFFFFFFE);
      wr(32'hC200_000C, 32'h10);
      wr(32'hC200_0000, 1);
      repeat (k) @(posedge clk);
      #1 rd_chk($sformatf("wrap%0d", k), 32'hC200_0008, 32'hFFFFFFFF + 32'(k));
      rd_chk("wrap_status", 32'hC200_0010, 32'h0);
    end

    // W1C on the same edge as a match: set wins
    do_reset();
    wr(32'hC200_000C, 3);
    wr(32'hC200_0000, 5);
    repeat (2) @(posedge clk);
    #1 wr(32'hC200_0010, 1);
    chk("w1c_race_irq", {31'b0, irq}, 32'd1);
    rd_chk("w1c_race_status", 32'hC200_0010, 32'h1);
    wr(32'hC200_0010, 1);
    chk("w1c_irq_drop", {31'b0, irq}, 32'd0);
    rd_chk("w1c_status", 32'hC200_0010, 32'h0);

    // COUNT write on a tick: bus wins, match uses pre-write count
    do_reset();
    wr(32'hC200_000C, 2);
    wr(32'hC200_0000, 1);
    @(posedge clk);
    #1 wr(32'hC200_0008, 32'h100);
    rd_chk("cnt_wr_tick", 32'hC200_0008, 32'h101);
    rd_chk("cnt_wr_match", 32'hC200_0010, 32'h1);

    // reset asserted during ACK
    do_reset();
    wr(32'hC200_0000, 7);
    repeat (2) @(posedge clk);
    #1 chk("pre_rst_irq", {31'b0, irq}, 32'd1);
    mem_s_addr = 32'hC200_0008; mem_s_wdata = 32'h55; mem_s_wstrb = 4'hF; mem_s_valid = 1;
    @(posedge clk); #1;
    chk("ack_before_rst", {31'b0, mem_s_ready}, 32'd1);
    reset = 1;
    @(posedge clk); #1;
    chk("rst_ack_ready", {31'b0, mem_s_ready}, 32'd0);
    chk("rst_ack_irq", {31'b0, irq}, 32'd0);
    mem_s_valid = 0; reset = 0;
    for (int i = 0; i < 5; i++) rd_chk($sformatf("rst_reg%0d", i), 32'hC200_0000 + 32'(i*4), 32'h0);

    // random traffic checked by the scoreboard
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 59) == 0) do_reset();
      d = $urandom;
      if ($urandom_range(0, 3) != 0) d = d & 32'h7;
      s = ($urandom_range(0, 2) == 0) ? 4'h0 : ($urandom_range(0, 1) ? 4'hF : 4'($urandom_range(1, 15)));
      bus(32'hC200_0000 + 32'($urandom_range(0, 7) * 4), d, s, r);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
